// File: rtl/signed_mult_seq.sv
// Sequencer for signed fixed-point multiplication around an external
// registered unsigned W x W multiplier.
//
// Flow: accept two signed Q(W-FRAC).FRAC operands, drive their magnitudes to
// the multiplier, wait MUL_LAT cycles, then round the unsigned product (half
// away from zero), re-apply the sign, saturate to W bits and pulse valid_o.
//
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - asynchronous active-high reset
//   start_i   - request, accepted only while ready_o is high
//   ready_o   - high in IDLE only
//   Data_A_i  - signed operand A, sampled on accept
//   Data_B_i  - signed operand B, sampled on accept
//   Mult_A_o  - registered |A| to the multiplier
//   Mult_B_o  - registered |B| to the multiplier
//   Mult_P_i  - 2W-bit unsigned product from the multiplier
//   Data_S_o  - signed rounded/saturated result, registered
//   valid_o   - one-cycle pulse when Data_S_o is updated
//   ovf_o     - saturation flag, same timing as Data_S_o

module signed_mult_seq #(
    parameter int unsigned W       = 32,
    parameter int unsigned FRAC    = 16,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    output logic           ready_o,
    input  logic [W-1:0]   Data_A_i,
    input  logic [W-1:0]   Data_B_i,
    output logic [W-1:0]   Mult_A_o,
    output logic [W-1:0]   Mult_B_o,
    input  logic [2*W-1:0] Mult_P_i,
    output logic [W-1:0]   Data_S_o,
    output logic           valid_o,
    output logic           ovf_o
);

    localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_LAT - 1);

    // Working width 2W+1 so the rounding increment can never lose a carry.
    localparam logic [2*W:0] One    = {{(2*W){1'b0}}, 1'b1};
    localparam logic [2*W:0] Rnd    = One << (FRAC - 1);
    localparam logic [2*W:0] MinMag = One << (W - 1);
    localparam logic [2*W:0] MaxPos = MinMag - One;
    localparam logic [W-1:0] OneW   = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StNorm
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [W-1:0]    mult_a_q, mult_a_d;
    logic [W-1:0]    mult_b_q, mult_b_d;
    logic [W-1:0]    data_s_q, data_s_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;

    logic [W-1:0]    abs_a, abs_b;
    logic [2*W:0]    rnd_sum;
    logic [2*W:0]    rnd_val;

    // The most negative operand maps to 2^(W-1), which is representable unsigned.
    assign abs_a = Data_A_i[W-1] ? (~Data_A_i + OneW) : Data_A_i;
    assign abs_b = Data_B_i[W-1] ? (~Data_B_i + OneW) : Data_B_i;

    assign rnd_sum = {1'b0, Mult_P_i} + Rnd;
    assign rnd_val = rnd_sum >> FRAC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            data_s_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
            data_s_q <= data_s_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        data_s_d = data_s_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mult_a_d = abs_a;
                    mult_b_d = abs_b;
                    sign_d   = Data_A_i[W-1] ^ Data_B_i[W-1];
                    cnt_d    = '0;
                    state_d  = StMul;
                end
            end
            StMul: begin
                if (cnt_q == CntLast) begin
                    state_d = StNorm;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StNorm: begin
                if (!sign_q) begin
                    if (rnd_val > MaxPos) begin
                        data_s_d = {1'b0, {(W-1){1'b1}}};
                        ovf_d    = 1'b1;
                    end else begin
                        data_s_d = rnd_val[W-1:0];
                        ovf_d    = 1'b0;
                    end
                end else begin
                    if (rnd_val > MinMag) begin
                        data_s_d = {1'b1, {(W-1){1'b0}}};
                        ovf_d    = 1'b1;
                    end else begin
                        // Magnitude 2^(W-1) negates to itself, which is -2^(W-1).
                        data_s_d = ~rnd_val[W-1:0] + OneW;
                        ovf_d    = 1'b0;
                    end
                end
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready_o  = (state_q == StIdle);
    assign Mult_A_o = mult_a_q;
    assign Mult_B_o = mult_b_q;
    assign Data_S_o = data_s_q;
    assign valid_o  = valid_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_signed_mult_seq.sv
// Self-checking bench for signed_mult_seq: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.

module tb_signed_mult_seq;

    localparam int unsigned W       = 32;
    localparam int unsigned FRAC    = 16;
    localparam int unsigned MUL_LAT = 1;

    logic           clk;
    logic           rst;
    logic           start_i;
    logic           ready_o;
    logic [W-1:0]   Data_A_i;
    logic [W-1:0]   Data_B_i;
    logic [W-1:0]   Mult_A_o;
    logic [W-1:0]   Mult_B_o;
    logic [2*W-1:0] Mult_P_i;
    logic [W-1:0]   Data_S_o;
    logic           valid_o;
    logic           ovf_o;

    signed_mult_seq #(
        .W       (W),
        .FRAC    (FRAC),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .ready_o  (ready_o),
        .Data_A_i (Data_A_i),
        .Data_B_i (Data_B_i),
        .Mult_A_o (Mult_A_o),
        .Mult_B_o (Mult_B_o),
        .Mult_P_i (Mult_P_i),
        .Data_S_o (Data_S_o),
        .valid_o  (valid_o),
        .ovf_o    (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: MUL_LAT register stages.
    logic [2*W-1:0] ppipe [MUL_LAT];
    always @(posedge clk) begin
        ppipe[0] <= Mult_A_o * Mult_B_o;
        for (int i = 1; i < MUL_LAT; i++) ppipe[i] <= ppipe[i-1];
    end
    assign Mult_P_i = ppipe[MUL_LAT-1];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Signed product, rounded half away from zero, then saturated.
    function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] s, output logic ovf,
                                     output logic [W-1:0] ma, output logic [W-1:0] mb);
        longint sa, sb, p, r, half, maxv, minv;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ma   = W'(sa < 0 ? -sa : sa);
        mb   = W'(sb < 0 ? -sb : sb);
        p    = sa * sb;
        half = longint'(1) << (FRAC - 1);
        if (p >= 0) r = (p + half) >>> FRAC;
        else        r = -((-p + half) >>> FRAC);
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        ovf  = 1'b0;
        if (r > maxv) begin
            r = maxv; ovf = 1'b1;
        end else if (r < minv) begin
            r = minv; ovf = 1'b1;
        end
        s = W'(r);
    endfunction

    // Model state: cycles until result appears (0 = idle).
    int           m_phase;
    logic [W-1:0] m_ma, m_mb, m_pend_s, m_s;
    logic         m_pend_ovf, m_ovf, m_valid;
    int           n_exp_valid = 0;
    int           n_seen_valid = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_ma = '0; m_mb = '0; m_s = '0; m_ovf = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_phase == 0) begin
                if (start_i) begin
                    model_op(Data_A_i, Data_B_i, m_pend_s, m_pend_ovf, m_ma, m_mb);
                    m_phase = MUL_LAT + 1;
                end
            end else begin
                m_phase--;
                if (m_phase == 0) begin
                    m_valid = 1'b1;
                    m_s     = m_pend_s;
                    m_ovf   = m_pend_ovf;
                    n_exp_valid++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", 64'(ready_o), 64'(m_phase == 0));
            chk("valid", 64'(valid_o), 64'(m_valid));
            chk("data_s", 64'(Data_S_o), 64'(m_s));
            chk("ovf", 64'(ovf_o), 64'(m_ovf));
            if (m_phase != 0) begin
                chk("mult_a", 64'(Mult_A_o), 64'(m_ma));
                chk("mult_b", 64'(Mult_B_o), 64'(m_mb));
            end
            if (valid_o) n_seen_valid++;
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ma;
        logic [W-1:0] s;
        logic         ovf;
    } vec_t;

    vec_t vecs[8] = '{
        '{32'h00018000, 32'h00020000, 32'h00018000, 32'h00030000, 1'b0},
        '{32'hFFFE8000, 32'h00020000, 32'h00018000, 32'hFFFD0000, 1'b0},
        '{32'h00000001, 32'h00008000, 32'h00000001, 32'h00000001, 1'b0},
        '{32'hFFFFFFFF, 32'h00008000, 32'h00000001, 32'hFFFFFFFF, 1'b0},
        '{32'h00000001, 32'h00007FFF, 32'h00000001, 32'h00000000, 1'b0},
        '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1},
        '{32'h80000000, 32'h00010000, 32'h80000000, 32'h80000000, 1'b0},
        '{32'h80000000, 32'hFFFF0000, 32'h80000000, 32'h7FFFFFFF, 1'b1}
    };

    task automatic run_op(input vec_t v);
        int n;
        @(negedge clk);
        start_i  = 1'b1;
        Data_A_i = v.a;
        Data_B_i = v.b;
        @(negedge clk);
        start_i  = 1'b0;
        Data_A_i = 32'hDEADBEEF;
        Data_B_i = 32'h12345678;
        chk("lit_mult_a", 64'(Mult_A_o), 64'(v.ma));
        n = 0;
        while (!valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("lit_latency", 64'(n), 64'(MUL_LAT + 1));
        chk("lit_data_s", 64'(Data_S_o), 64'(v.s));
        chk("lit_ovf", 64'(ovf_o), 64'(v.ovf));
    endtask

    // Start an op, then assert reset asynchronously `wait_edges` edges after accept.
    task automatic reset_mid_op(input int wait_edges);
        @(negedge clk);
        start_i  = 1'b1;
        Data_A_i = 32'h00030000;
        Data_B_i = 32'hFFFF0000;
        @(posedge clk);
        for (int i = 0; i < wait_edges; i++) @(posedge clk);
        #2;
        start_i = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data_s", 64'(Data_S_o), 64'd0);
        chk("rst_mult_a", 64'(Mult_A_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        start_i  = 1'b0;
        Data_A_i = '0;
        Data_B_i = '0;
        #3;
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_data_s", 64'(Data_S_o), 64'd0);
        chk("reset_ovf", 64'(ovf_o), 64'd0);
        chk("reset_mult_a", 64'(Mult_A_o), 64'd0);
        chk("reset_mult_b", 64'(Mult_B_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Start held high with operands changing every cycle.
        @(negedge clk);
        start_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            Data_A_i = 32'h00013579 * (i + 1) ^ (i[0] ? 32'hFFF00000 : 32'h0);
            Data_B_i = 32'hFFFF8000 + 32'h00011234 * i;
            @(negedge clk);
        end
        start_i = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during MUL (just after accept) and during NORM.
        reset_mid_op(0);
        run_op(vecs[0]);
        reset_mid_op(MUL_LAT);
        run_op(vecs[1]);

        repeat (3) @(negedge clk);
        chk("valid_count", 64'(n_seen_valid), 64'(n_exp_valid));
        chk("valid_total", 64'(n_exp_valid), 64'(8 + 5 + 2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
